// File: rtl/clock_pkg.sv
// Shared time record, field limits and BCD helpers for the 12/24-hour timekeeper.
package clock_pkg;

   typedef struct packed {
      logic [4:0] hr;
      logic [5:0] min;
      logic [5:0] sec;
   } time_t;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [4:0] HR_MAX  = 5'd23;

   // HHMMSS in BCD, 24-hour: every digit a decimal digit and each field in range.
   function automatic logic bcd_time_valid(input logic [23:0] bcd);
      logic ok;
      ok = (bcd[23:20] <= 4'd2) && (bcd[19:16] <= 4'd9)
         && ((bcd[23:20] != 4'd2) || (bcd[19:16] <= 4'd3))
         && (bcd[15:12] <= 4'd5) && (bcd[11:8] <= 4'd9)
         && (bcd[7:4] <= 4'd5) && (bcd[3:0] <= 4'd9);
      return ok;
   endfunction

   function automatic time_t bcd_to_time(input logic [23:0] bcd);
      time_t t;
      t.hr  = {1'b0, bcd[23:20]} * 5'd10 + {1'b0, bcd[19:16]};
      t.min = {2'b00, bcd[15:12]} * 6'd10 + {2'b00, bcd[11:8]};
      t.sec = {2'b00, bcd[7:4]} * 6'd10 + {2'b00, bcd[3:0]};
      return t;
   endfunction

   function automatic int presc_width(input int ticks);
      return (ticks < 2) ? 1 : $clog2(ticks);
   endfunction

endpackage

// File: rtl/bcd_time_conv.sv
// Binary time to display BCD HHMMSS, with 12-hour remapping of the hour field.
module bcd_time_conv
   import clock_pkg::*;
(
   input  time_t       t,
   input  logic        mode_24,
   output logic [23:0] bcd,
   output logic        pm
);

   // Inputs never exceed 59, so the tens digit is 0..5 and the ones digit
   // can be recovered in 4-bit (mod 16) arithmetic.
   function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
      logic [3:0] tens;
      logic [3:0] tens_x10;
      if (v >= 6'd50)      tens = 4'd5;
      else if (v >= 6'd40) tens = 4'd4;
      else if (v >= 6'd30) tens = 4'd3;
      else if (v >= 6'd20) tens = 4'd2;
      else if (v >= 6'd10) tens = 4'd1;
      else                 tens = 4'd0;
      tens_x10 = tens * 4'd10;
      return {tens, v[3:0] - tens_x10};
   endfunction

   logic [4:0] hr_disp;

   always_comb begin
      pm      = (t.hr >= 5'd12);
      hr_disp = t.hr;
      if (!mode_24) begin
         if (t.hr == 5'd0)       hr_disp = 5'd12;
         else if (t.hr > 5'd12)  hr_disp = t.hr - 5'd12;
      end
      bcd = {bin_to_bcd({1'b0, hr_disp}), bin_to_bcd(t.min), bin_to_bcd(t.sec)};
   end

endmodule

// File: rtl/clock_12_24hr.sv
// Binary HH:MM:SS timekeeper with run-time 12/24-hour BCD display and a valid/ready set port.
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_12_24hr
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int RESET_HOUR    = 0
) (
   input  logic        kh_clk,
   input  logic        reset,
   input  logic        run,
   input  logic        mode_24,
   input  logic        set_valid,
   output logic        set_ready,
   input  logic [23:0] set_time,
   output logic        set_err,
   output logic        sec_tick,
   output logic [23:0] disp_time,
   output logic        pm
`ifdef CLOCK_ALARM_EN
   ,
   input  logic [23:0] alarm_time,
   input  logic        alarm_ack,
   output logic        alarm
`endif
);

   localparam int             PW         = presc_width(TICKS_PER_SEC);
   localparam logic [PW-1:0]  PRESC_TC   = PW'(TICKS_PER_SEC - 1);
   localparam time_t          RESET_TIME = {5'(RESET_HOUR), 12'd0};

   logic [PW-1:0] presc_q, presc_d;
   time_t         time_q, time_d;
   logic          ready_q, ready_d;
   logic          set_err_q, set_err_d;
   logic          adv_q, adv_d;
   logic          sec_tick_q, sec_tick_d;
   logic [23:0]   disp_q, disp_d;
   logic          pm_q, pm_d;
   logic          xfer;
   logic          set_ok;
   time_t         conv_time;

   assign set_ready = ready_q & ~reset;

   always_comb begin
      xfer      = set_valid & set_ready;
      set_ok    = bcd_time_valid(set_time);
      presc_d   = presc_q;
      time_d    = time_q;
      adv_d     = 1'b0;
      set_err_d = 1'b0;
      // A transfer, valid or not, pre-empts any tick on the same edge.
      if (xfer) begin
         if (set_ok) begin
            time_d  = bcd_to_time(set_time);
            presc_d = '0;
         end else begin
            set_err_d = 1'b1;
         end
      end else if (run) begin
         if (presc_q == PRESC_TC) begin
            presc_d = '0;
            adv_d   = 1'b1;
            if (time_q.sec != SEC_MAX) begin
               time_d.sec = time_q.sec + 6'd1;
            end else begin
               time_d.sec = '0;
               if (time_q.min != MIN_MAX) begin
                  time_d.min = time_q.min + 6'd1;
               end else begin
                  time_d.min = '0;
                  time_d.hr  = (time_q.hr == HR_MAX) ? 5'd0 : time_q.hr + 5'd1;
               end
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      ready_d    = ~xfer;
      sec_tick_d = adv_q;
   end

   // Converting the reset time during reset makes the display valid on the first cycle out.
   assign conv_time = reset ? RESET_TIME : time_q;

   bcd_time_conv u_disp_conv (
      .t       (conv_time),
      .mode_24 (mode_24),
      .bcd     (disp_d),
      .pm      (pm_d)
   );

   always_ff @(posedge kh_clk) begin
      if (reset) begin
         presc_q    <= '0;
         time_q     <= RESET_TIME;
         ready_q    <= 1'b0;
         set_err_q  <= 1'b0;
         adv_q      <= 1'b0;
         sec_tick_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         time_q     <= time_d;
         ready_q    <= ready_d;
         set_err_q  <= set_err_d;
         adv_q      <= adv_d;
         sec_tick_q <= sec_tick_d;
      end
      disp_q <= disp_d;
      pm_q   <= pm_d;
   end

   assign set_err   = set_err_q;
   assign sec_tick  = sec_tick_q;
   assign disp_time = disp_q;
   assign pm        = pm_q;

`ifdef CLOCK_ALARM_EN
   logic match_q, match_d;
   logic alarm_q, alarm_d;

   // Match is judged on the new internal time; the flag rises one edge later with the display.
   always_comb begin
      match_d = ((xfer & set_ok) | adv_d) & bcd_time_valid(alarm_time)
              & (time_d == bcd_to_time(alarm_time));
      alarm_d = match_q | (alarm_q & ~alarm_ack);
   end

   always_ff @(posedge kh_clk) begin
      if (reset) begin
         match_q <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         match_q <= match_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_12_24hr.sv
// Self-checking bench for clock_12_24hr against a seconds-of-day reference model.
module tb_clock_12_24hr;

   localparam int TPS        = 4;
   localparam int RESET_HOUR = 0;
   localparam int DAY        = 86400;

   logic        kh_clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        mode_24 = 1'b0;
   logic        set_valid = 1'b0;
   logic        set_ready;
   logic [23:0] set_time = '0;
   logic        set_err;
   logic        sec_tick;
   logic [23:0] disp_time;
   logic        pm;
`ifdef CLOCK_ALARM_EN
   logic [23:0] alarm_time = '0;
   logic        alarm_ack = 1'b0;
   logic        alarm;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: time of day in seconds plus run-cycle count into the current second
   int          m_tod = 0;
   int          m_pc = 0;
   bit          m_rdy = 1'b0;
   bit          m_adv = 1'b0;
   logic [23:0] e_disp = '0;
   bit          e_pm = 1'b0;
   bit          e_tick = 1'b0;
   bit          e_err = 1'b0;
   bit          m_match = 1'b0;
   bit          e_alarm = 1'b0;

   always #5 kh_clk = ~kh_clk;

   clock_12_24hr #(.TICKS_PER_SEC(TPS), .RESET_HOUR(RESET_HOUR)) dut (
      .kh_clk     (kh_clk),
      .reset      (reset),
      .run        (run),
      .mode_24    (mode_24),
      .set_valid  (set_valid),
      .set_ready  (set_ready),
      .set_time   (set_time),
      .set_err    (set_err),
      .sec_tick   (sec_tick),
      .disp_time  (disp_time),
      .pm         (pm)
`ifdef CLOCK_ALARM_EN
      ,
      .alarm_time (alarm_time),
      .alarm_ack  (alarm_ack),
      .alarm      (alarm)
`endif
   );

   function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] fmt(input int tod, input bit m24);
      int h;
      h = tod / 3600;
      if (!m24) begin
         h = h % 12;
         if (h == 0) h = 12;
      end
      return to_bcd(h, (tod / 60) % 60, tod % 60);
   endfunction

   function automatic bit bcd_ok(input logic [23:0] v);
      int d[6];
      for (int i = 0; i < 6; i++) d[i] = int'(v[i*4 +: 4]);
      for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
      return (d[5] * 10 + d[4] <= 23) && (d[3] * 10 + d[2] <= 59) && (d[1] * 10 + d[0] <= 59);
   endfunction

   function automatic int bcd_tod(input logic [23:0] v);
      int d[6];
      for (int i = 0; i < 6; i++) d[i] = int'(v[i*4 +: 4]);
      return (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
   endfunction

   // One clock edge: advance the model with the inputs held across the edge, then settle.
   task automatic step();
      bit rdy_now;
      bit xfer;
      bit adv;
      bit loaded;
      bit err;
      @(posedge kh_clk);
      rdy_now = m_rdy && !reset;
      if (reset) begin
         m_tod   = RESET_HOUR * 3600;
         m_pc    = 0;
         m_rdy   = 1'b0;
         m_adv   = 1'b0;
         e_err   = 1'b0;
         e_tick  = 1'b0;
         e_disp  = fmt(m_tod, mode_24);
         e_pm    = (m_tod >= 12 * 3600);
         m_match = 1'b0;
         e_alarm = 1'b0;
      end else begin
         xfer   = set_valid && rdy_now;
         e_disp = fmt(m_tod, mode_24);
         e_pm   = (m_tod >= 12 * 3600);
         e_tick = m_adv;
`ifdef CLOCK_ALARM_EN
         e_alarm = m_match || (e_alarm && !alarm_ack);
`endif
         adv = 1'b0;
         loaded = 1'b0;
         err = 1'b0;
         if (xfer) begin
            if (bcd_ok(set_time)) begin
               m_tod  = bcd_tod(set_time);
               m_pc   = 0;
               loaded = 1'b1;
            end else begin
               err = 1'b1;
            end
         end else if (run) begin
            m_pc++;
            if (m_pc == TPS) begin
               m_pc  = 0;
               m_tod = (m_tod + 1) % DAY;
               adv   = 1'b1;
            end
         end
         m_adv = adv;
         e_err = err;
         m_rdy = !xfer;
`ifdef CLOCK_ALARM_EN
         m_match = (adv || loaded) && bcd_ok(alarm_time) && (m_tod == bcd_tod(alarm_time));
`else
         m_match = loaded;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; mode_24 = 1'b0; set_valid = 1'b0;
      step();
      step();
      checks++; if (disp_time !== 24'h120000) begin errors++; $display("FAIL reset_disp got %h exp %h", disp_time, 24'h120000); end
      checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm got %b exp 0", pm); end
      checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b exp 0", set_ready); end
      checks++; if (sec_tick !== 1'b0 || set_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got tick %b err %b exp 0 0", sec_tick, set_err); end
      reset = 1'b0;
      #1;
      checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_first got %b exp 0", set_ready); end
      step();
      checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", set_ready); end
      checks++; if (disp_time !== 24'h120000) begin errors++; $display("FAIL reset_disp_hold got %h exp %h", disp_time, 24'h120000); end
   endtask

   task automatic test_wrap();
      logic [23:0] exp_d;
      bit          exp_t;
      mode_24 = 1'b1; run = 1'b1;
      set_time = 24'h235958; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready_after_xfer got %b exp 0", set_ready); end
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_d = (k < 5) ? 24'h235958 : (k < 9) ? 24'h235959 : 24'h000000;
         exp_t = (k == 5) || (k == 9);
         checks++; if (disp_time !== exp_d) begin errors++; $display("FAIL wrap_disp k=%0d got %h exp %h", k, disp_time, exp_d); end
         checks++; if (sec_tick !== exp_t) begin errors++; $display("FAIL wrap_tick k=%0d got %b exp %b", k, sec_tick, exp_t); end
         checks++; if (disp_time !== e_disp) begin errors++; $display("FAIL wrap_model k=%0d got %h exp %h", k, disp_time, e_disp); end
      end
   endtask

   task automatic test_12h();
      mode_24 = 1'b0; run = 1'b1;
      set_time = 24'h115959; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 1) begin
            checks++; if (disp_time !== 24'h115959 || pm !== 1'b0) begin errors++; $display("FAIL h12_before_noon got %h/%b exp 115959/0", disp_time, pm); end
         end
      end
      checks++; if (disp_time !== 24'h120000 || pm !== 1'b1) begin errors++; $display("FAIL h12_noon got %h/%b exp 120000/1", disp_time, pm); end
      mode_24 = 1'b1;
      step();
      checks++; if (disp_time !== 24'h120000 || pm !== 1'b1) begin errors++; $display("FAIL h24_noon got %h/%b exp 120000/1", disp_time, pm); end
      mode_24 = 1'b0;
      set_time = 24'h130000; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      step();
      checks++; if (disp_time !== 24'h010000 || pm !== 1'b1) begin errors++; $display("FAIL h12_13h got %h/%b exp 010000/1", disp_time, pm); end
   endtask

   task automatic test_err();
      logic [23:0] bad [4];
      int          n;
      bad[0] = 24'h246000; bad[1] = 24'h235960; bad[2] = 24'h006000; bad[3] = 24'h00000A;
      run = 1'b0; mode_24 = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         set_time = bad[i]; set_valid = 1'b1;
         step();
         set_valid = 1'b0;
         checks++; if (set_err !== 1'b1) begin errors++; $display("FAIL err_pulse %h got %b exp 1", bad[i], set_err); end
         step();
         checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL err_width %h got %b exp 0", bad[i], set_err); end
         checks++; if (disp_time !== 24'h130000) begin errors++; $display("FAIL err_keep %h got %h exp 130000", bad[i], disp_time); end
      end
      run = 1'b1;
      n = 0;
      while (m_pc != TPS - 1 && n < 3 * TPS) begin
         step();
         n++;
      end
      checks++; if (m_pc != TPS - 1) begin errors++; $display("FAIL tc_wait got pc %0d exp %0d", m_pc, TPS - 1); end
      set_time = 24'h010203; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL tc_set_tick k=%0d got %b exp 0", k, sec_tick); end
         checks++; if (disp_time !== 24'h010203) begin errors++; $display("FAIL tc_set_disp k=%0d got %h exp 010203", k, disp_time); end
      end
   endtask

   task automatic test_run_stop();
      run = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         checks++; if (disp_time !== 24'h010203) begin errors++; $display("FAIL frozen k=%0d got %h exp 010203", k, disp_time); end
      end
      run = 1'b1;
      for (int k = 0; k < 6; k++) step();
      checks++; if (disp_time !== e_disp) begin errors++; $display("FAIL resumed got %h exp %h", disp_time, e_disp); end
      reset = 1'b1; mode_24 = 1'b1;
      step();
      checks++; if (disp_time !== 24'h000000 || pm !== 1'b0) begin errors++; $display("FAIL mid_reset got %h/%b exp 000000/0", disp_time, pm); end
      checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b exp 0", set_ready); end
      reset = 1'b0;
      step();
      checks++; if (disp_time !== 24'h000000) begin errors++; $display("FAIL post_reset got %h exp 000000", disp_time); end
   endtask

`ifdef CLOCK_ALARM_EN
   task automatic test_alarm();
      bit exp_a;
      mode_24 = 1'b1; run = 1'b1;
      alarm_time = 24'h000002;
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      set_time = 24'h000000; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         exp_a = (k >= 9);
         checks++; if (alarm !== exp_a) begin errors++; $display("FAIL alarm_rise k=%0d got %b exp %b", k, alarm, exp_a); end
         if (k == 9) begin
            checks++; if (disp_time !== 24'h000002) begin errors++; $display("FAIL alarm_disp got %h exp 000002", disp_time); end
         end
      end
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_ack got %b exp 0", alarm); end
      set_time = 24'h000001; set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      alarm_ack = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp_a = (k == 5);
         checks++; if (alarm !== exp_a) begin errors++; $display("FAIL alarm_ack_on_match k=%0d got %b exp %b", k, alarm, exp_a); end
      end
      alarm_ack = 1'b0;
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         run   = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode_24 = ~mode_24;
         set_valid = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 1) == 1) set_time = fmt($urandom_range(0, DAY - 1), 1'b1);
         else                           set_time = 24'($urandom);
`ifdef CLOCK_ALARM_EN
         if ($urandom_range(0, 31) == 0) alarm_time = fmt((m_tod + $urandom_range(0, 3)) % DAY, 1'b1);
         alarm_ack = ($urandom_range(0, 15) == 0);
`endif
         #1;
         checks++; if (set_ready !== (m_rdy && !reset)) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, set_ready, m_rdy && !reset); end
         step();
         checks++; if (disp_time !== e_disp || pm !== e_pm) begin errors++; $display("FAIL rnd_disp c=%0d got %h/%b exp %h/%b", c, disp_time, pm, e_disp, e_pm); end
         checks++; if (sec_tick !== e_tick) begin errors++; $display("FAIL rnd_tick c=%0d got %b exp %b", c, sec_tick, e_tick); end
         checks++; if (set_err !== e_err) begin errors++; $display("FAIL rnd_err c=%0d got %b exp %b", c, set_err, e_err); end
`ifdef CLOCK_ALARM_EN
         checks++; if (alarm !== e_alarm) begin errors++; $display("FAIL rnd_alarm c=%0d got %b exp %b", c, alarm, e_alarm); end
`endif
      end
      reset = 1'b0; set_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_12h();
      test_err();
      test_run_stop();
`ifdef CLOCK_ALARM_EN
      test_alarm();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule
